// File: rtl/vga_pkg.sv
// Shared VGA timing constants, the timing-set payload and a timing sanity helper.
package vga_pkg;

  localparam int unsigned VGA_FW = 16;

  localparam int unsigned DEF_H_SIZE = 640;
  localparam int unsigned DEF_H_FP   = 656;
  localparam int unsigned DEF_H_SP   = 752;
  localparam int unsigned DEF_H_MAX  = 800;
  localparam int unsigned DEF_V_SIZE = 480;
  localparam int unsigned DEF_V_FP   = 490;
  localparam int unsigned DEF_V_SP   = 492;
  localparam int unsigned DEF_V_MAX  = 525;
  localparam logic        DEF_HSPP   = 1'b0;
  localparam logic        DEF_VSPP   = 1'b0;

  typedef struct packed {
    logic [VGA_FW-1:0] h_size;
    logic [VGA_FW-1:0] h_fp;
    logic [VGA_FW-1:0] h_sp;
    logic [VGA_FW-1:0] h_max;
    logic [VGA_FW-1:0] v_size;
    logic [VGA_FW-1:0] v_fp;
    logic [VGA_FW-1:0] v_sp;
    logic [VGA_FW-1:0] v_max;
    logic              hspp;
    logic              vspp;
  } vga_timing_t;

  // One axis is usable when size <= fp < sp <= max and the line/frame has at least 2 steps.
  function automatic logic axis_ok(input logic [VGA_FW-1:0] size, input logic [VGA_FW-1:0] fp,
                                   input logic [VGA_FW-1:0] sp, input logic [VGA_FW-1:0] mx);
    return (size <= fp) && (fp < sp) && (sp <= mx) && (mx >= VGA_FW'(2));
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated register pipeline with a reset value; zero depth is a plain wire.
module vga_delay_line #(
  parameter int unsigned   W       = 1,
  parameter int unsigned   DEPTH   = 2,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q = d;
    end else begin : g_pipe
      logic [W-1:0] stg [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < int'(DEPTH); i++) stg[i] <= RST_VAL;
        end else if (en) begin
          stg[0] <= d;
          for (int i = 1; i < int'(DEPTH); i++) stg[i] <= stg[i-1];
        end
      end

      assign q = stg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/DE generator with run-time timing reload, applied only at frame boundaries.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned DELAY  = 2,
  parameter int unsigned H_SIZE = DEF_H_SIZE,
  parameter int unsigned H_FP   = DEF_H_FP,
  parameter int unsigned H_SP   = DEF_H_SP,
  parameter int unsigned H_MAX  = DEF_H_MAX,
  parameter int unsigned V_SIZE = DEF_V_SIZE,
  parameter int unsigned V_FP   = DEF_V_FP,
  parameter int unsigned V_SP   = DEF_V_SP,
  parameter int unsigned V_MAX  = DEF_V_MAX,
  parameter logic        HSPP   = DEF_HSPP,
  parameter logic        VSPP   = DEF_VSPP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_h_size,
  input  logic [WIDTH-1:0] cfg_h_fp,
  input  logic [WIDTH-1:0] cfg_h_sp,
  input  logic [WIDTH-1:0] cfg_h_max,
  input  logic [WIDTH-1:0] cfg_v_size,
  input  logic [WIDTH-1:0] cfg_v_fp,
  input  logic [WIDTH-1:0] cfg_v_sp,
  input  logic [WIDTH-1:0] cfg_v_max,
  input  logic             cfg_hspp,
  input  logic             cfg_vspp,
  output logic             cfg_pending,
  output logic             cfg_err,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [WIDTH-1:0] hdata,
  output logic [WIDTH-1:0] vdata,
  output logic             sof,
  output logic             eol
);

  localparam int unsigned PW = 5 + 2 * WIDTH;

  localparam vga_timing_t DEF_SET = '{
    h_size: VGA_FW'(H_SIZE), h_fp: VGA_FW'(H_FP), h_sp: VGA_FW'(H_SP), h_max: VGA_FW'(H_MAX),
    v_size: VGA_FW'(V_SIZE), v_fp: VGA_FW'(V_FP), v_sp: VGA_FW'(V_SP), v_max: VGA_FW'(V_MAX),
    hspp: HSPP, vspp: VSPP
  };

  // Payload order: hsync, vsync, de, sof, eol, hdata, vdata; syncs idle at the default polarity.
  localparam logic [PW-1:0] RST_VAL = {~HSPP, ~VSPP, {(PW-2){1'b0}}};

  vga_timing_t      act;
  vga_timing_t      pend;
  vga_timing_t      cfg_set_c;
  logic             pend_v;
  logic [WIDTH-1:0] h;
  logic [WIDTH-1:0] v;
  logic             h_last_c;
  logic             v_last_c;
  logic             wrap_c;
  logic             wr_ok_c;
  logic             h_in_sync_c;
  logic             v_in_sync_c;
  logic [PW-1:0]    dec_c;
  logic [PW-1:0]    stage0;
  logic [PW-1:0]    pipe_q;

  always_comb begin
    cfg_set_c = '{
      h_size: VGA_FW'(cfg_h_size), h_fp: VGA_FW'(cfg_h_fp), h_sp: VGA_FW'(cfg_h_sp),
      h_max: VGA_FW'(cfg_h_max), v_size: VGA_FW'(cfg_v_size), v_fp: VGA_FW'(cfg_v_fp),
      v_sp: VGA_FW'(cfg_v_sp), v_max: VGA_FW'(cfg_v_max), hspp: cfg_hspp, vspp: cfg_vspp
    };
    wr_ok_c  = axis_ok(cfg_set_c.h_size, cfg_set_c.h_fp, cfg_set_c.h_sp, cfg_set_c.h_max) &&
               axis_ok(cfg_set_c.v_size, cfg_set_c.v_fp, cfg_set_c.v_sp, cfg_set_c.v_max);
    h_last_c = VGA_FW'(h) == act.h_max - VGA_FW'(1);
    v_last_c = VGA_FW'(v) == act.v_max - VGA_FW'(1);
    wrap_c   = en && h_last_c && v_last_c;
  end

  // Timing-set bookkeeping: a pending set swaps in only on the frame wrap edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act     <= DEF_SET;
      pend    <= DEF_SET;
      pend_v  <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !wr_ok_c;
      if (wrap_c && pend_v) act <= pend;
      if (cfg_we && wr_ok_c) begin
        pend   <= cfg_set_c;
        pend_v <= 1'b1;
      end else if (wrap_c) begin
        pend_v <= 1'b0;
      end
    end
  end

  assign cfg_pending = pend_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (en) begin
      if (h_last_c) begin
        h <= '0;
        v <= v_last_c ? '0 : v + WIDTH'(1);
      end else begin
        h <= h + WIDTH'(1);
      end
    end
  end

  always_comb begin
    h_in_sync_c = (VGA_FW'(h) >= act.h_fp) && (VGA_FW'(h) < act.h_sp);
    v_in_sync_c = (VGA_FW'(v) >= act.v_fp) && (VGA_FW'(v) < act.v_sp);
    dec_c = {
      h_in_sync_c ? act.hspp : ~act.hspp,
      v_in_sync_c ? act.vspp : ~act.vspp,
      (VGA_FW'(h) < act.h_size) && (VGA_FW'(v) < act.v_size),
      (h == '0) && (v == '0),
      h_last_c,
      h,
      v
    };
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     stage0 <= RST_VAL;
    else if (en) stage0 <= dec_c;
  end

  vga_delay_line #(
    .W       (PW),
    .DEPTH   (DELAY),
    .RST_VAL (RST_VAL)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (stage0),
    .q   (pipe_q)
  );

  assign {hsync, vsync, de, sof, eol, hdata, vdata} = pipe_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized scoreboard bench for vga_timing_gen using a pixel-index reference model.
module tb_vga_timing_gen;

  localparam int unsigned W   = 12;
  localparam int unsigned DLY = 2;

  typedef struct {
    int hs, hf, hp, hm, vs, vf, vp, vm;
    bit hpol, vpol;
  } tmg_t;

  typedef struct packed {
    logic hsync, vsync, de, sof, eol;
    logic [W-1:0] hd, vd;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst, en, cfg_we;
  logic [W-1:0] cfg_h_size, cfg_h_fp, cfg_h_sp, cfg_h_max;
  logic [W-1:0] cfg_v_size, cfg_v_fp, cfg_v_sp, cfg_v_max;
  logic         cfg_hspp, cfg_vspp;
  logic         cfg_pending, cfg_err, hsync, vsync, de, sof, eol;
  logic [W-1:0] hdata, vdata;
  obs_t         dut_o;

  vga_timing_gen #(
    .WIDTH(W), .DELAY(DLY),
    .H_SIZE(16), .H_FP(18), .H_SP(22), .H_MAX(26),
    .V_SIZE(8), .V_FP(9), .V_SP(11), .V_MAX(12),
    .HSPP(1'b0), .VSPP(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we),
    .cfg_h_size(cfg_h_size), .cfg_h_fp(cfg_h_fp), .cfg_h_sp(cfg_h_sp), .cfg_h_max(cfg_h_max),
    .cfg_v_size(cfg_v_size), .cfg_v_fp(cfg_v_fp), .cfg_v_sp(cfg_v_sp), .cfg_v_max(cfg_v_max),
    .cfg_hspp(cfg_hspp), .cfg_vspp(cfg_vspp),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err),
    .hsync(hsync), .vsync(vsync), .de(de), .hdata(hdata), .vdata(vdata),
    .sof(sof), .eol(eol)
  );

  always #5 clk = ~clk;
  assign dut_o = {hsync, vsync, de, sof, eol, hdata, vdata};

  int checks = 0;
  int errors = 0;

  function automatic tmg_t def_tmg();
    tmg_t t;
    t.hs = 16; t.hf = 18; t.hp = 22; t.hm = 26;
    t.vs = 8;  t.vf = 9;  t.vp = 11; t.vm = 12;
    t.hpol = 1'b0; t.vpol = 1'b1;
    return t;
  endfunction

  function automatic bit tmg_ok(tmg_t t);
    return t.hs <= t.hf && t.hf < t.hp && t.hp <= t.hm && t.hm >= 2 &&
           t.vs <= t.vf && t.vf < t.vp && t.vp <= t.vm && t.vm >= 2;
  endfunction

  // Expected output for linear pixel index p of a frame in timing t.
  function automatic obs_t expect_at(tmg_t t, int p);
    obs_t o;
    int x, y;
    x = p % t.hm;
    y = p / t.hm;
    o.hsync = (x >= t.hf && x < t.hp) ? t.hpol : ~t.hpol;
    o.vsync = (y >= t.vf && y < t.vp) ? t.vpol : ~t.vpol;
    o.de    = (x < t.hs) && (y < t.vs);
    o.sof   = (p == 0);
    o.eol   = (x == t.hm - 1);
    o.hd    = W'(x);
    o.vd    = W'(y);
    return o;
  endfunction

  function automatic obs_t rst_obs();
    obs_t o;
    tmg_t d;
    d = def_tmg();
    o = '0;
    o.hsync = ~d.hpol;
    o.vsync = ~d.vpol;
    return o;
  endfunction

  function automatic tmg_t rand_tmg(bit bad);
    tmg_t t;
    t.hs = $urandom_range(20, 4); t.hf = t.hs + $urandom_range(3, 0);
    t.hp = t.hf + 1 + $urandom_range(4, 0); t.hm = t.hp + $urandom_range(4, 0);
    t.vs = $urandom_range(10, 2); t.vf = t.vs + $urandom_range(2, 0);
    t.vp = t.vf + 1 + $urandom_range(2, 0); t.vm = t.vp + $urandom_range(2, 0);
    t.hpol = 1'($urandom_range(1, 0)); t.vpol = 1'($urandom_range(1, 0));
    if (bad) begin
      case ($urandom_range(2, 0))
        0:       t.hf = t.hp;
        1:       t.vm = t.vp - 1;
        default: t.hs = t.hf + 1;
      endcase
    end
    return t;
  endfunction

  function automatic tmg_t pins_tmg();
    tmg_t t;
    t.hs = int'(cfg_h_size); t.hf = int'(cfg_h_fp); t.hp = int'(cfg_h_sp); t.hm = int'(cfg_h_max);
    t.vs = int'(cfg_v_size); t.vf = int'(cfg_v_fp); t.vp = int'(cfg_v_sp); t.vm = int'(cfg_v_max);
    t.hpol = cfg_hspp; t.vpol = cfg_vspp;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: frame position as one linear pixel index, timing sets as records.
  tmg_t   m_act, m_pend, m_cfg;
  bit     m_pv, m_err, m_en_edge, m_wrap, m_cfg_ok;
  int     m_p;
  obs_t   exp_q[$];

  always @(posedge clk) begin
    m_en_edge = 1'b0;
    if (rst) begin
      m_act = def_tmg(); m_pend = def_tmg();
      m_pv = 1'b0; m_err = 1'b0; m_p = 0;
      exp_q.delete();
    end else begin
      m_cfg    = pins_tmg();
      m_cfg_ok = tmg_ok(m_cfg);
      m_wrap   = en && (m_p == m_act.hm * m_act.vm - 1);
      m_err    = cfg_we && !m_cfg_ok;
      if (en) begin
        exp_q.push_back(expect_at(m_act, m_p));
        m_p = m_wrap ? 0 : m_p + 1;
        m_en_edge = 1'b1;
      end
      if (m_wrap && m_pv) m_act = m_pend;
      if (cfg_we && m_cfg_ok) begin
        m_pend = m_cfg;
        m_pv   = 1'b1;
      end else if (m_wrap) begin
        m_pv = 1'b0;
      end
    end
  end

  // Monitor: an enabled edge presents a new pixel once the pipeline is primed.
  obs_t mon_exp, mon_last;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      mon_exp  = rst_obs();
      mon_last = mon_exp;
    end else if (m_en_edge && exp_q.size() > DLY) begin
      mon_exp  = exp_q.pop_front();
      mon_last = mon_exp;
    end else begin
      mon_exp = mon_last;
    end
    chk("video_out", 64'(dut_o), 64'(mon_exp));
    chk("cfg_pending", 64'(cfg_pending), 64'(m_pv));
    chk("cfg_err", 64'(cfg_err), 64'(m_err));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_cfg(input tmg_t t);
    cfg_h_size = W'(t.hs); cfg_h_fp = W'(t.hf); cfg_h_sp = W'(t.hp); cfg_h_max = W'(t.hm);
    cfg_v_size = W'(t.vs); cfg_v_fp = W'(t.vf); cfg_v_sp = W'(t.vp); cfg_v_max = W'(t.vm);
    cfg_hspp = t.hpol; cfg_vspp = t.vpol;
  endtask

  task automatic write_cfg(input tmg_t t);
    drive_cfg(t);
    cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  tmg_t t_bad, t_a, t_b;
  int   waited;

  initial begin
    rst = 1'b1; en = 1'b0; cfg_we = 1'b0;
    drive_cfg(def_tmg());
    cyc(3);
    rst = 1'b0; en = 1'b1;
    cyc(2 * 312 + 20);

    // freeze mid-line, then resume
    cyc(7);
    en = 1'b0; cyc(50); en = 1'b1;
    cyc(100);

    // rejected write: front porch beyond sync end
    t_bad = def_tmg(); t_bad.hf = 24; t_bad.hp = 20;
    write_cfg(t_bad);
    cyc(320);

    // accepted write mid-frame, applied at the next wrap
    cyc(26 * 5);
    write_cfg(rand_tmg(1'b0));
    cyc(1500);

    // A pending, B written exactly on the wrap edge
    t_a = rand_tmg(1'b0);
    t_b = rand_tmg(1'b0);
    write_cfg(t_a);
    waited = 0;
    while (!(m_p == m_act.hm * m_act.vm - 1) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 2000) begin
      errors++;
      $display("FAIL wrap_wait: got timeout expected wrap position within 2000 cycles");
    end
    write_cfg(t_b);
    cyc(1800);

    // randomized enable gaps and writes, some invalid
    repeat (3000) begin
      en = ($urandom_range(9, 0) != 0);
      if ($urandom_range(199, 0) == 0) write_cfg(rand_tmg($urandom_range(2, 0) == 0));
      else cyc(1);
    end
    en = 1'b1;
    cyc(50);

    // reset mid-frame with a pending set
    write_cfg(rand_tmg(1'b0));
    cyc(17);
    rst = 1'b1;
    #1;
    chk("rst_immediate_out", 64'(dut_o), 64'(rst_obs()));
    chk("rst_immediate_pending", 64'(cfg_pending), 64'(0));
    @(negedge clk);
    cyc(2);
    rst = 1'b0;
    cyc(700);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter WIDTH, default 12, bit width of all counters and timing fields.
REQ-002 Parameter DELAY, default 2, range 0..7, extra output pipeline stages for alignment with a downstream pixel pipeline.
REQ-003 Parameters H_SIZE/H_FP/H_SP/H_MAX/V_SIZE/V_FP/V_SP/V_MAX/HSPP/VSPP, defaults 640/656/752/800/480/490/492/525/0/0, reset-time timing (VGA 640x480@60).
REQ-004 clk  in  1  pixel clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 en  in  1  counter advance enable; 0 holds the counters and the pipeline.
REQ-007 cfg_we  in  1  single-cycle write strobe for a new timing set.
REQ-008 cfg_h_size, cfg_h_fp, cfg_h_sp, cfg_h_max, cfg_v_size, cfg_v_fp, cfg_v_sp, cfg_v_max  in  WIDTH each  new timing values.
REQ-009 cfg_hspp, cfg_vspp  in  1 each  new sync polarities (0 = negative, 1 = positive).
REQ-010 cfg_pending  out  1  a written set is waiting to be applied.
REQ-011 cfg_err  out  1  one-cycle pulse: last cfg_we was rejected.
REQ-012 hsync, vsync  out  1  sync outputs, polarity per active set.
REQ-013 de  out  1  active-video flag.
REQ-014 hdata, vdata  out  WIDTH  pixel/line position aligned with de.
REQ-015 sof, eol  out  1  start-of-frame pulse at (0,0); end-of-line pulse at hdata = h_max-1.

Function
REQ-016 Counters: h advances 0..h_max-1 when en=1; v advances on h wrap and runs 0..v_max-1; both wrap to 0.
REQ-017 Decode per counter state: sync asserted while fp <= cnt < sp; de = h < h_size AND v < v_size; asserted level = polarity bit.
REQ-018 Outputs are registered; the total latency from counter state to output is 1+DELAY enabled clocks; all outputs are delayed identically.
REQ-019 en=0 freezes the counters and every pipeline stage; outputs hold their values.
REQ-020 cfg_we accepted only if size <= fp < sp <= max and max >= 2 on both axes; otherwise it is ignored, cfg_err pulses the next cycle, and the pending set is unchanged.
REQ-021 Accepted write loads the pending register and sets cfg_pending=1; a second write before application overwrites it.
REQ-022 Pending set becomes active on the enabled edge where the counters wrap from (h_max-1, v_max-1) to (0,0); cfg_pending clears on the same edge.
REQ-023 cfg_we on the wrap edge: the previously pending set is applied, the new set is stored, and cfg_pending stays 1.
REQ-024 The active set never changes mid-frame; the counters never exceed the active max.

Reset
REQ-025 rst forces h=v=0, active set = parameter defaults, pending empty, cfg_pending=0, cfg_err=0.
REQ-026 During and after rst all pipeline stages hold de=0, sof=0, eol=0, hdata=vdata=0, and syncs at the inactive level of the default polarity.
REQ-027 rst mid-frame or mid-pending discards the pending set; counting resumes from (0,0) on the first enabled edge after release.

Structure
REQ-028 Package vga_pkg holds the default timing constants and a timing-set struct typedef (4 h fields, 4 v fields, 2 polarity bits).
REQ-029 One sub-module vga_delay_line (parametrised width, depth DELAY, enable, async reset value) implements the output pipeline; DELAY=0 is a direct pass-through.

Verification
REQ-030 Defaults, DELAY=2, en=1: one frame -> 800x525 clocks; hsync low for 96 clocks per line; vsync low on lines 490-491; de high for 640x480; sof at clock 3 after reset release.
REQ-031 Valid write at line 100 to 800x600 timing (1056/600/628, 840/968, 601/605) -> current frame finishes as 640x480; next frame has de 800x600 and cfg_pending falls at the wrap.
REQ-032 Write with cfg_h_fp=700 and cfg_h_sp=600 -> cfg_err single pulse, cfg_pending unchanged, timing unchanged.
REQ-033 cfg_we exactly on the wrap edge with A pending and new B -> A is active in the next frame, B in the one after, and cfg_pending stays high until the second wrap.
REQ-034 en low for 50 clocks mid-line -> all outputs frozen; after en returns, the sequence continues with no skipped or duplicated pixel.
REQ-035 rst pulse mid-frame with a pending set -> outputs go to the reset values immediately, the defaults are active after release, and cfg_pending=0.
